// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// State encoding, instruction field values, ALU codes and datapath mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_JR     = 4'd13
  } state_e;

  // What the ALU should do in a state; the decoder turns this into a 4-bit code.
  typedef enum logic [2:0] {
    ACLS_ADD   = 3'd0,
    ACLS_SUB   = 3'd1,
    ACLS_FUNCT = 3'd2,
    ACLS_PASSA = 3'd3,
    ACLS_ZERO  = 3'd4
  } alu_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD      = 6'h20;
  localparam logic [5:0] FUNCT_SUB      = 6'h22;
  localparam logic [5:0] FUNCT_AND      = 6'h24;
  localparam logic [5:0] FUNCT_OR       = 6'h25;
  localparam logic [5:0] FUNCT_JR       = 6'h08;
  localparam logic [5:0] FUNCT_MIN_DEF  = 6'h38;
  localparam logic [5:0] FUNCT_XNOR_DEF = 6'h39;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_MIN   = 4'b0111;
  localparam logic [3:0] ALU_XNOR  = 4'b1100;
  localparam logic [3:0] ALU_PASSA = 4'b0011;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU function decoder: maps the state's ALU class and the R-type
// funct field to the 4-bit ALU code, and flags funct values the core does not support.
module mc_alu_decoder
  import mc_pkg::*;
#(
  parameter logic [5:0] FUNCT_MIN  = FUNCT_MIN_DEF,
  parameter logic [5:0] FUNCT_XNOR = FUNCT_XNOR_DEF
) (
  input  alu_class_e  aluClass_i,
  input  logic [5:0]  funct_i,
  output logic [3:0]  aluControl_o,
  output logic        functBad_o
);

  logic [3:0] functCode;

  // jr is a legal funct but never reaches the funct-driven ALU path.
  always_comb begin
    functCode  = ALU_ADD;
    functBad_o = 1'b0;
    case (funct_i)
      FUNCT_ADD:  functCode = ALU_ADD;
      FUNCT_SUB:  functCode = ALU_SUB;
      FUNCT_AND:  functCode = ALU_AND;
      FUNCT_OR:   functCode = ALU_OR;
      FUNCT_MIN:  functCode = ALU_MIN;
      FUNCT_XNOR: functCode = ALU_XNOR;
      FUNCT_JR:   functCode = ALU_ADD;
      default:    functBad_o = 1'b1;
    endcase
  end

  always_comb begin
    aluControl_o = ALU_ADD;
    case (aluClass_i)
      ACLS_ADD:   aluControl_o = ALU_ADD;
      ACLS_SUB:   aluControl_o = ALU_SUB;
      ACLS_FUNCT: aluControl_o = functCode;
      ACLS_PASSA: aluControl_o = ALU_PASSA;
      ACLS_ZERO:  aluControl_o = 4'b0000;
      default:    aluControl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: sequences the shared datapath one state per cycle,
// with all outputs decoded combinationally from the state register and live inputs.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter logic [5:0] FUNCT_MIN  = FUNCT_MIN_DEF,
  parameter logic [5:0] FUNCT_XNOR = FUNCT_XNOR_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op
);

  state_e     state_q, state_d;
  alu_class_e aluClass;
  logic       pcWrite;
  logic       branch;
  logic       functBad;

  mc_alu_decoder #(
    .FUNCT_MIN  (FUNCT_MIN),
    .FUNCT_XNOR (FUNCT_XNOR)
  ) u_alu_decoder (
    .aluClass_i   (aluClass),
    .funct_i      (funct),
    .aluControl_o (alu_control),
    .functBad_o   (functBad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pcWrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_source  = PCSRC_ALU;
    aluClass   = ACLS_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      // PC+4 is computed every FETCH cycle but only committed with the IR load.
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pcWrite  = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_RTYPE: begin
            if (functBad) begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end else if (funct == FUNCT_JR) begin
              state_d = S_JR;
            end else begin
              state_d = S_EXEC;
            end
          end
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        aluClass  = ACLS_FUNCT;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      // IR is frozen after FETCH, so opcode still tells lw from sw here.
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        aluClass   = ACLS_SUB;
        branch     = 1'b1;
        pc_source  = PCSRC_ALUOUT;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pcWrite    = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JR: begin
        alu_src_a  = 1'b1;
        aluClass   = ACLS_PASSA;
        pc_source  = PCSRC_JR;
        pcWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      default: begin
        aluClass = ACLS_ZERO;
        state_d  = S_FETCH;
      end
    endcase
  end

  assign pc_en = pcWrite | (branch & zero);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle
// and compares the whole control word against hand-built expected vectors.
module tb_mc_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_control;
  logic       instr_done, illegal_op;

  int checkCount = 0;
  int errorCount = 0;

  logic [18:0] cwOut;

  mc_control_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_source   (pc_source),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cwOut = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, pc_source, alu_control,
                  instr_done, illegal_op};

  // Packs a control word in the same bit order as cwOut.
  function automatic logic [18:0] cw(input logic pe, input logic io, input logic mr,
                                     input logic mw, input logic irw, input logic rd,
                                     input logic m2r, input logic rw, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] ps,
                                     input logic [3:0] alu, input logic dn,
                                     input logic il);
    return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ps, alu, dn, il};
  endfunction

  task automatic checkOutput(input string tag, input logic [18:0] actual,
                             input logic [18:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %05h expected %05h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic mr, input logic z);
    opcode    = op;
    funct     = fn;
    mem_ready = mr;
    zero      = z;
    #1;
  endtask

  task automatic runCycle(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic mr, input logic z, input logic [18:0] expected);
    applyStimulus(op, fn, mr, z);
    checkOutput(tag, cwOut, expected);
    @(posedge clk);
    #1;
  endtask

  logic [18:0] eIdle, eFetch, eFetchWait, eDecode, eDecodeIll, eAluWb, eMemAdr;
  logic [18:0] eMemRd, eMemWb, eMemWrWait, eMemWrDone, eBrTaken, eBrNot;
  logic [18:0] eAddiWb, eJump, eJr;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    eIdle      = cw(0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'b0010,0,0);
    eFetch     = cw(1,0,1,0,1,0,0,0,0,2'b01,2'b00,4'b0010,0,0);
    eFetchWait = cw(0,0,1,0,0,0,0,0,0,2'b01,2'b00,4'b0010,0,0);
    eDecode    = cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,0,0);
    eDecodeIll = cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,0,1);
    eAluWb     = cw(0,0,0,0,0,1,0,1,0,2'b00,2'b00,4'b0010,1,0);
    eMemAdr    = cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0,0);
    eMemRd     = cw(0,1,1,0,0,0,0,0,0,2'b00,2'b00,4'b0010,0,0);
    eMemWb     = cw(0,0,0,0,0,0,1,1,0,2'b00,2'b00,4'b0010,1,0);
    eMemWrWait = cw(0,1,0,1,0,0,0,0,0,2'b00,2'b00,4'b0010,0,0);
    eMemWrDone = cw(0,1,0,1,0,0,0,0,0,2'b00,2'b00,4'b0010,1,0);
    eBrTaken   = cw(1,0,0,0,0,0,0,0,1,2'b00,2'b01,4'b0110,1,0);
    eBrNot     = cw(0,0,0,0,0,0,0,0,1,2'b00,2'b01,4'b0110,1,0);
    eAddiWb    = cw(0,0,0,0,0,0,0,1,0,2'b00,2'b00,4'b0010,1,0);
    eJump      = cw(1,0,0,0,0,0,0,0,0,2'b00,2'b10,4'b0010,1,0);
    eJr        = cw(1,0,0,0,0,0,0,0,1,2'b00,2'b11,4'b0011,1,0);

    rst_n = 1'b0;
    applyStimulus(6'h00, 6'h20, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", cwOut, eIdle);
    rst_n = 1'b1;
    runCycle("idle", 6'h00, 6'h20, 1'b1, 1'b0, eIdle);

    // add
    runCycle("add fetch",  6'h00, 6'h20, 1'b1, 1'b0, eFetch);
    runCycle("add decode", 6'h00, 6'h20, 1'b1, 1'b0, eDecode);
    runCycle("add exec",   6'h00, 6'h20, 1'b1, 1'b0, cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'b0010,0,0));
    runCycle("add wb",     6'h00, 6'h20, 1'b1, 1'b0, eAluWb);

    // xnor and min through the parameterised funct codes
    runCycle("xnor fetch",  6'h00, 6'h39, 1'b1, 1'b0, eFetch);
    runCycle("xnor decode", 6'h00, 6'h39, 1'b1, 1'b0, eDecode);
    runCycle("xnor exec",   6'h00, 6'h39, 1'b1, 1'b0, cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'b1100,0,0));
    runCycle("xnor wb",     6'h00, 6'h39, 1'b1, 1'b0, eAluWb);
    runCycle("min fetch",   6'h00, 6'h38, 1'b1, 1'b0, eFetch);
    runCycle("min decode",  6'h00, 6'h38, 1'b1, 1'b0, eDecode);
    runCycle("min exec",    6'h00, 6'h38, 1'b1, 1'b0, cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'b0111,0,0));
    runCycle("min wb",      6'h00, 6'h38, 1'b1, 1'b0, eAluWb);
    runCycle("sub fetch",   6'h00, 6'h22, 1'b1, 1'b0, eFetch);
    runCycle("sub decode",  6'h00, 6'h22, 1'b1, 1'b0, eDecode);
    runCycle("sub exec",    6'h00, 6'h22, 1'b1, 1'b0, cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'b0110,0,0));
    runCycle("sub wb",      6'h00, 6'h22, 1'b1, 1'b0, eAluWb);

    // lw with one fetch stall and two memory-read stalls
    runCycle("lw fetch wait", 6'h23, 6'h00, 1'b0, 1'b0, eFetchWait);
    runCycle("lw fetch",      6'h23, 6'h00, 1'b1, 1'b0, eFetch);
    runCycle("lw decode",     6'h23, 6'h00, 1'b1, 1'b0, eDecode);
    runCycle("lw memadr",     6'h23, 6'h00, 1'b1, 1'b0, eMemAdr);
    runCycle("lw memrd w1",   6'h23, 6'h00, 1'b0, 1'b0, eMemRd);
    runCycle("lw memrd w2",   6'h23, 6'h00, 1'b0, 1'b0, eMemRd);
    runCycle("lw memrd",      6'h23, 6'h00, 1'b1, 1'b0, eMemRd);
    runCycle("lw memwb",      6'h23, 6'h00, 1'b1, 1'b0, eMemWb);

    // beq taken and not taken
    runCycle("beq1 fetch",  6'h04, 6'h00, 1'b1, 1'b1, eFetch);
    runCycle("beq1 decode", 6'h04, 6'h00, 1'b1, 1'b1, eDecode);
    runCycle("beq1 branch", 6'h04, 6'h00, 1'b1, 1'b1, eBrTaken);
    runCycle("beq0 fetch",  6'h04, 6'h00, 1'b1, 1'b0, eFetch);
    runCycle("beq0 decode", 6'h04, 6'h00, 1'b1, 1'b0, eDecode);
    runCycle("beq0 branch", 6'h04, 6'h00, 1'b1, 1'b0, eBrNot);

    // j, addi, jr
    runCycle("j fetch",      6'h02, 6'h00, 1'b1, 1'b0, eFetch);
    runCycle("j decode",     6'h02, 6'h00, 1'b1, 1'b0, eDecode);
    runCycle("j jump",       6'h02, 6'h00, 1'b1, 1'b0, eJump);
    runCycle("addi fetch",   6'h08, 6'h00, 1'b1, 1'b0, eFetch);
    runCycle("addi decode",  6'h08, 6'h00, 1'b1, 1'b0, eDecode);
    runCycle("addi ex",      6'h08, 6'h00, 1'b1, 1'b0, eMemAdr);
    runCycle("addi wb",      6'h08, 6'h00, 1'b1, 1'b0, eAddiWb);
    runCycle("jr fetch",     6'h00, 6'h08, 1'b1, 1'b0, eFetch);
    runCycle("jr decode",    6'h00, 6'h08, 1'b1, 1'b0, eDecode);
    runCycle("jr exec",      6'h00, 6'h08, 1'b1, 1'b0, eJr);

    // unsupported opcode, then unsupported R-type funct
    runCycle("illop fetch",  6'h3F, 6'h00, 1'b1, 1'b0, eFetch);
    runCycle("illop decode", 6'h3F, 6'h00, 1'b1, 1'b0, eDecodeIll);
    runCycle("illfn fetch",  6'h00, 6'h21, 1'b1, 1'b0, eFetch);
    runCycle("illfn decode", 6'h00, 6'h21, 1'b1, 1'b0, eDecodeIll);

    // sw stalled in MEMWR, completed once, then aborted by reset
    runCycle("sw fetch",     6'h2B, 6'h00, 1'b1, 1'b0, eFetch);
    runCycle("sw decode",    6'h2B, 6'h00, 1'b1, 1'b0, eDecode);
    runCycle("sw memadr",    6'h2B, 6'h00, 1'b1, 1'b0, eMemAdr);
    runCycle("sw memwr w",   6'h2B, 6'h00, 1'b0, 1'b0, eMemWrWait);
    runCycle("sw memwr",     6'h2B, 6'h00, 1'b1, 1'b0, eMemWrDone);
    runCycle("sw2 fetch",    6'h2B, 6'h00, 1'b1, 1'b0, eFetch);
    runCycle("sw2 decode",   6'h2B, 6'h00, 1'b1, 1'b0, eDecode);
    runCycle("sw2 memadr",   6'h2B, 6'h00, 1'b1, 1'b0, eMemAdr);
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
    checkOutput("sw2 memwr w", cwOut, eMemWrWait);
    rst_n = 1'b0;
    #1;
    checkOutput("reset abort", cwOut, eIdle);
    @(posedge clk);
    #1;
    checkOutput("reset hold", cwOut, eIdle);
    rst_n = 1'b1;
    runCycle("post idle",  6'h00, 6'h20, 1'b0, 1'b0, eIdle);
    runCycle("post fetch", 6'h00, 6'h20, 1'b0, 1'b0, eFetchWait);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
